// File: rtl/dmem_port_arbiter.sv
// Data memory port arbiter: shares one combinational-read data memory between
// the core load/store port and an external port (loader / debug / DMA).
// One access per cycle, round-robin under contention, with a bounded external
// burst lock so the core can never be starved for more than MAX_EXT_BURST+1
// cycles. Grants are combinational (zero latency); only the priority, burst
// counter and stall statistics are registered.
module dmem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_EXT_BURST = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    output logic [DATA_W-1:0] core_rdata_o,
    output logic              core_stall_o,
    input  logic              ext_req_i,
    input  logic              ext_we_i,
    input  logic              ext_lock_i,
    input  logic [ADDR_W-1:0] ext_addr_i,
    input  logic [DATA_W-1:0] ext_wdata_i,
    output logic [DATA_W-1:0] ext_rdata_o,
    output logic              ext_ack_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [15:0]       stall_cnt_o
);

    // Counter must hold 0..MAX_EXT_BURST inclusive.
    localparam int BURST_W = (MAX_EXT_BURST < 1) ? 1 : $clog2(MAX_EXT_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_EXT_BURST);

    typedef enum logic {
        PRIO_CORE = 1'b0,
        PRIO_EXT  = 1'b1
    } prio_t;

    prio_t              prio_reg;
    prio_t              prio_next;
    logic [BURST_W-1:0] burst_cnt_reg;
    logic [BURST_W-1:0] burst_cnt_next;
    logic [15:0]        stall_cnt_reg;
    logic [15:0]        stall_cnt_next;

    logic ext_wins;
    logic gnt_ext;
    logic gnt_core;
    logic contested;

    // Grant decision: the lock only wins while the burst budget lasts; after
    // that contention falls back to plain round-robin priority. Nothing is
    // granted while in reset so no write can reach the memory.
    always_comb begin
        ext_wins  = (ext_lock_i && (burst_cnt_reg < BURST_MAX)) || (prio_reg == PRIO_EXT);
        gnt_ext   = !reset_i && ext_req_i && (!core_req_i || ext_wins);
        gnt_core  = !reset_i && core_req_i && !gnt_ext;
        contested = core_req_i && ext_req_i;
    end

    // Memory-side mux: the external port only drives the memory when granted;
    // otherwise address/data follow the core port.
    always_comb begin
        mem_addr_o   = gnt_ext ? ext_addr_i  : core_addr_i;
        mem_wdata_o  = gnt_ext ? ext_wdata_i : core_wdata_i;
        mem_re_o     = (gnt_ext && !ext_we_i) || (gnt_core && !core_we_i);
        mem_we_o     = (gnt_ext && ext_we_i)  || (gnt_core && core_we_i);
        core_rdata_o = mem_rdata_i;
        ext_rdata_o  = mem_rdata_i;
        core_stall_o = !reset_i && core_req_i && !gnt_core;
        ext_ack_o    = gnt_ext;
        stall_cnt_o  = stall_cnt_reg;
    end

    // Next-state: priority goes to the loser of a contested cycle, the burst
    // counter only advances while the lock actually holds off a waiting core.
    always_comb begin
        prio_next      = prio_reg;
        burst_cnt_next = burst_cnt_reg;
        stall_cnt_next = stall_cnt_reg;

        if (contested && gnt_ext) begin
            prio_next = PRIO_CORE;
        end else if (contested && gnt_core) begin
            prio_next = PRIO_EXT;
        end

        if (!ext_lock_i) begin
            burst_cnt_next = '0;
        end else if (gnt_ext && core_req_i) begin
            if (burst_cnt_reg < BURST_MAX) begin
                burst_cnt_next = burst_cnt_reg + 1'b1;
            end
        end else if (gnt_core) begin
            burst_cnt_next = '0;
        end

        if (core_stall_o && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_next = stall_cnt_reg + 16'd1;
        end
    end

    // State registers with synchronous reset back to core priority.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prio_reg      <= PRIO_CORE;
            burst_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            prio_reg      <= prio_next;
            burst_cnt_reg <= burst_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a small word memory model sits behind
// the main instance; a second instance with a long burst budget is used to
// drive the stall counter into saturation quickly.
module tb_dmem_port_arbiter;

    logic        clk;
    logic        reset_i;
    logic        core_req_i, core_we_i;
    logic [31:0] core_addr_i, core_wdata_i, core_rdata_o;
    logic        core_stall_o;
    logic        ext_req_i, ext_we_i, ext_lock_i;
    logic [31:0] ext_addr_i, ext_wdata_i, ext_rdata_o;
    logic        ext_ack_o;
    logic        mem_re_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [15:0] stall_cnt_o;

    // Saturation instance signals
    logic        s_reset;
    logic [31:0] s_core_rdata, s_ext_rdata, s_mem_addr, s_mem_wdata;
    logic        s_core_stall, s_ext_ack, s_mem_re, s_mem_we;
    logic [15:0] s_stall_cnt;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_EXT_BURST(4)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i),
        .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
        .core_rdata_o(core_rdata_o), .core_stall_o(core_stall_o),
        .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_lock_i(ext_lock_i),
        .ext_addr_i(ext_addr_i), .ext_wdata_i(ext_wdata_i),
        .ext_rdata_o(ext_rdata_o), .ext_ack_o(ext_ack_o),
        .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .stall_cnt_o(stall_cnt_o)
    );

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_EXT_BURST(200)) dut_sat (
        .clk_i(clk), .reset_i(s_reset),
        .core_req_i(1'b1), .core_we_i(1'b0),
        .core_addr_i(32'h0000_0010), .core_wdata_i(32'h0),
        .core_rdata_o(s_core_rdata), .core_stall_o(s_core_stall),
        .ext_req_i(1'b1), .ext_we_i(1'b0), .ext_lock_i(1'b1),
        .ext_addr_i(32'h0000_0020), .ext_wdata_i(32'h0),
        .ext_rdata_o(s_ext_rdata), .ext_ack_o(s_ext_ack),
        .mem_re_o(s_mem_re), .mem_we_o(s_mem_we),
        .mem_addr_o(s_mem_addr), .mem_wdata_o(s_mem_wdata),
        .mem_rdata_i(32'h0), .stall_cnt_o(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: combinational read, write on the rising edge.
    assign mem_rdata_i = mem[mem_addr_o[9:2]];
    always @(posedge clk) begin
        if (mem_we_o) mem[mem_addr_o[9:2]] <= mem_wdata_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        core_req_i = 1'b0; core_we_i = 1'b0; core_addr_i = 32'h0; core_wdata_i = 32'h0;
        ext_req_i = 1'b0; ext_we_i = 1'b0; ext_lock_i = 1'b0;
        ext_addr_i = 32'h0; ext_wdata_i = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        s_reset = 1'b1;
        reset_i = 1'b1;
        idle_inputs();

        // ---- Core store asserted during reset: nothing reaches memory
        @(negedge clk);
        core_req_i = 1'b1; core_we_i = 1'b1;
        core_addr_i = 32'h80; core_wdata_i = 32'h1234_5678;
        #1;
        chk("rst_mem_we", 32'(mem_we_o), 32'd0);
        chk("rst_mem_re", 32'(mem_re_o), 32'd0);
        chk("rst_stall", 32'(core_stall_o), 32'd0);
        ext_req_i = 1'b1;
        #1;
        chk("rst_ext_ack", 32'(ext_ack_o), 32'd0);
        @(negedge clk);
        chk("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
        $display("txn reset store: we=%0b re=%0b", mem_we_o, mem_re_o);

        // ---- Core-only load of 0x10
        idle_inputs();
        reset_i = 1'b0;
        core_req_i = 1'b1; core_addr_i = 32'h10;
        #1;
        chk("core_ld_re", 32'(mem_re_o), 32'd1);
        chk("core_ld_we", 32'(mem_we_o), 32'd0);
        chk("core_ld_addr", mem_addr_o, 32'h10);
        chk("core_ld_stall", 32'(core_stall_o), 32'd0);
        chk("core_ld_stall_cnt", 32'(stall_cnt_o), 32'd0);
        chk("core_ld_rdata", core_rdata_o, 32'hA5A5_0004);
        $display("txn core load 0x10: rdata=%h", core_rdata_o);

        // ---- Contention without lock: CORE, EXT, CORE, EXT
        @(negedge clk);
        core_req_i = 1'b1; core_addr_i = 32'h10;
        ext_req_i = 1'b1; ext_addr_i = 32'h20;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("rr_ack", 32'(ext_ack_o), 32'(c % 2));
            chk("rr_stall", 32'(core_stall_o), 32'(c % 2));
            chk("rr_addr", mem_addr_o, (c % 2 == 1) ? 32'h20 : 32'h10);
            $display("txn rr cycle %0d: ack=%0b stall=%0b addr=%h", c, ext_ack_o, core_stall_o, mem_addr_o);
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk("rr_stall_cnt", 32'(stall_cnt_o), 32'd2);

        // ---- Burst lock: 4 ext grants, core on 5th, counter cleared
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        core_req_i = 1'b1; core_addr_i = 32'h10;
        ext_req_i = 1'b1; ext_lock_i = 1'b1; ext_addr_i = 32'h24;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("lock_ack", 32'(ext_ack_o), (c == 4) ? 32'd0 : 32'd1);
            chk("lock_stall", 32'(core_stall_o), (c == 4) ? 32'd0 : 32'd1);
            $display("txn lock cycle %0d: ack=%0b stall=%0b", c, ext_ack_o, core_stall_o);
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk("lock_stall_cnt", 32'(stall_cnt_o), 32'd5);

        // ---- External write then core load of same address
        @(negedge clk);
        ext_req_i = 1'b1; ext_we_i = 1'b1;
        ext_addr_i = 32'h40; ext_wdata_i = 32'hDEAD_BEEF;
        #1;
        chk("ext_wr_ack", 32'(ext_ack_o), 32'd1);
        chk("ext_wr_we", 32'(mem_we_o), 32'd1);
        chk("ext_wr_addr", mem_addr_o, 32'h40);
        chk("ext_wr_data", mem_wdata_o, 32'hDEAD_BEEF);
        $display("txn ext write 0x40 <= %h", mem_wdata_o);
        @(negedge clk);
        idle_inputs();
        core_req_i = 1'b1; core_addr_i = 32'h40;
        #1;
        chk("core_rd_after_ext", core_rdata_o, 32'hDEAD_BEEF);
        chk("core_rd_re", 32'(mem_re_o), 32'd1);
        $display("txn core load 0x40: rdata=%h", core_rdata_o);

        // ---- Store attempted in reset must not have reached 0x80
        @(negedge clk);
        core_addr_i = 32'h80;
        #1;
        chk("rst_store_blocked", core_rdata_o, 32'hA5A5_0020);
        $display("txn core load 0x80: rdata=%h", core_rdata_o);

        // ---- Idle: no enables, address follows core port
        @(negedge clk);
        idle_inputs();
        core_addr_i = 32'h44;
        ext_addr_i = 32'h99;
        #1;
        chk("idle_re", 32'(mem_re_o), 32'd0);
        chk("idle_we", 32'(mem_we_o), 32'd0);
        chk("idle_addr", mem_addr_o, 32'h44);
        $display("txn idle: addr=%h", mem_addr_o);

        // ---- Stall counter saturation (period 201: 200 stalls, 1 grant)
        @(negedge clk);
        s_reset = 1'b0;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        chk("sat_mid_cnt", 32'(s_stall_cnt), 32'd996);
        $display("txn sat after 1000 cycles: cnt=%0d", s_stall_cnt);
        repeat (65000) @(posedge clk);
        @(negedge clk);
        chk("sat_cnt", 32'(s_stall_cnt), 32'h0000_FFFF);
        repeat (300) @(posedge clk);
        @(negedge clk);
        chk("sat_hold", 32'(s_stall_cnt), 32'h0000_FFFF);
        $display("txn sat final: cnt=%h", s_stall_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
